// File: rtl/aes_bus_arbiter.sv
// aes_bus_arbiter
// Two-master Wishbone arbiter in front of the single AES accelerator slave.
// M0 is the Caravel management bus, M1 a debug master driven from LA bits.
// Round-robin on ties, grant held for a whole transaction, slave timeout
// recovery with a sticky flag, and a one-cycle DONE gap between transactions.
//
// Ports:
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   m0_* / m1_*              master Wishbone interfaces (cyc/stb/we/sel/adr/dat in, ack/dat out)
//   s_*                      slave side towards the AES io_bus_* interface
//   timeout_flag_o           sticky timeout indication, cleared by timeout_clr_i
//   grant_o                  one-hot current grant {m1,m0}
//   stat_m0_o, stat_m1_o     saturating grant counters
//
// Optional feature: define ARB_STATS_EN to build the grant counters;
// without it both stat ports are tied to zero.
module aes_bus_arbiter #(
    parameter int ADDR_W         = 28,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [3:0]        m0_sel_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [31:0]       m0_dat_i,
    output logic              m0_ack_o,
    output logic [31:0]       m0_dat_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [3:0]        m1_sel_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [31:0]       m1_dat_i,
    output logic              m1_ack_o,
    output logic [31:0]       m1_dat_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [3:0]        s_sel_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [31:0]       s_dat_o,
    input  logic              s_ack_i,
    input  logic [31:0]       s_dat_i,
    output logic              timeout_flag_o,
    input  logic              timeout_clr_i,
    output logic [1:0]        grant_o,
    output logic [15:0]       stat_m0_o,
    output logic [15:0]       stat_m1_o
);

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [31:0] TMO_DATA  = 32'hBAD0_BAD0;

    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2, DONE = 2'd3} state_t;

    state_t      state;
    logic        last_grant;   // 0: M0 won last arbitration, 1: M1
    logic [15:0] wait_cnt;
    logic        flag;

    logic req0, req1, start0, start1, gnt0, gnt1, cur_cyc, tmo;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    // On a tie the master that did not win last time takes the grant.
    assign start0 = (state == IDLE) & req0 & (~req1 | last_grant);
    assign start1 = (state == IDLE) & req1 & ~start0;

    // Reset masks the granted path in the same cycle so an in-flight
    // transaction is dropped without an ack even if the slave answers.
    assign gnt0 = (state == GNT0) & ~wb_rst_i;
    assign gnt1 = (state == GNT1) & ~wb_rst_i;

    assign cur_cyc = gnt0 ? m0_cyc_i : m1_cyc_i;
    assign tmo     = (gnt0 | gnt1) & cur_cyc & (wait_cnt == TMO_LIMIT);

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (gnt0) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (gnt1) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
        // The timed-out cycle withdraws the request from the slave.
        if (tmo) begin
            s_cyc_o = 1'b0;
            s_stb_o = 1'b0;
        end
    end

    // A slave ack in the timeout cycle is ignored; the error word wins.
    assign m0_ack_o = gnt0 & m0_cyc_i & (tmo | s_ack_i);
    assign m1_ack_o = gnt1 & m1_cyc_i & (tmo | s_ack_i);
    assign m0_dat_o = ~m0_ack_o ? 32'h0 : (tmo ? TMO_DATA : s_dat_i);
    assign m1_dat_o = ~m1_ack_o ? 32'h0 : (tmo ? TMO_DATA : s_dat_i);

    assign grant_o        = {gnt1, gnt0};
    assign timeout_flag_o = flag;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start0) begin
                        state      <= GNT0;
                        last_grant <= 1'b0;
                        wait_cnt   <= '0;
                    end else if (start1) begin
                        state      <= GNT1;
                        last_grant <= 1'b1;
                        wait_cnt   <= '0;
                    end
                end
                GNT0, GNT1: begin
                    // Ack, abort (cyc dropped) or timeout all end the grant.
                    if (!cur_cyc || s_ack_i || tmo) begin
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Set has priority over clear.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            flag <= 1'b0;
        end else if (tmo) begin
            flag <= 1'b1;
        end else if (timeout_clr_i) begin
            flag <= 1'b0;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] stat0, stat1;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            stat0 <= '0;
            stat1 <= '0;
        end else begin
            if (start0 && stat0 != 16'hFFFF) begin
                stat0 <= stat0 + 16'd1;
            end
            if (start1 && stat1 != 16'hFFFF) begin
                stat1 <= stat1 + 16'd1;
            end
        end
    end

    assign stat_m0_o = stat0;
    assign stat_m1_o = stat1;
`else
    assign stat_m0_o = 16'h0000;
    assign stat_m1_o = 16'h0000;
`endif

endmodule

// File: tb/tb_aes_bus_arbiter.sv
// Testbench for aes_bus_arbiter: directed scenarios followed by randomized
// rounds, checked against a transaction-level reference model.
module tb_aes_bus_arbiter;

    localparam int ADDR_W = 28;
    localparam int TMO    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              m_cyc [2];
    logic              m_stb [2];
    logic              m_we  [2];
    logic [3:0]        m_sel [2];
    logic [ADDR_W-1:0] m_adr [2];
    logic [31:0]       m_dat [2];
    logic              m0_ack, m1_ack;
    logic [31:0]       m0_rd, m1_rd;
    logic              s_cyc, s_stb, s_we, s_ack;
    logic [3:0]        s_sel;
    logic [ADDR_W-1:0] s_adr;
    logic [31:0]       s_wdat, s_rdat;
    logic              flag, clr;
    logic [1:0]        grant;
    logic [15:0]       st0, st1;

    aes_bus_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]),
        .m0_sel_i(m_sel[0]), .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]),
        .m0_ack_o(m0_ack), .m0_dat_o(m0_rd),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]),
        .m1_sel_i(m_sel[1]), .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]),
        .m1_ack_o(m1_ack), .m1_dat_o(m1_rd),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_dat_i(s_rdat),
        .timeout_flag_o(flag), .timeout_clr_i(clr), .grant_o(grant),
        .stat_m0_o(st0), .stat_m1_o(st1)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    // Reference model state
    int   prev_winner;
    int   exp_stat [2];
    logic exp_flag;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    function automatic logic ack_of(input int g);
        return (g == 1) ? m1_ack : m0_ack;
    endfunction

    function automatic logic [31:0] rd_of(input int g);
        return (g == 1) ? m1_rd : m0_rd;
    endfunction

    function automatic logic [15:0] exp_st(input int i);
`ifdef ARB_STATS_EN
        return 16'(exp_stat[i]);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic model_reset();
        prev_winner = 1;
        exp_stat[0] = 0;
        exp_stat[1] = 0;
        exp_flag    = 1'b0;
    endtask

    task automatic setup(input int i);
        m_we[i]  = 1'($urandom);
        m_sel[i] = 4'($urandom);
        m_adr[i] = ADDR_W'($urandom);
        m_dat[i] = $urandom;
    endtask

    // Entered just before the first granted cycle; returns at the ack cycle.
    task automatic serve(input int g, input int w, input bit tmo);
        int          last;
        logic [31:0] rd;
        last = tmo ? TMO : w;
        prev_winner = g;
        exp_stat[g]++;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            clr    = 1'b0;
            rd     = $urandom;
            s_ack  = (!tmo && k == w);
            s_rdat = rd;
            if (tmo && k == last) clr = 1'($urandom);
            #1;
            if (k == 0) begin
                check("grant", {30'd0, grant}, (g == 1) ? 32'd2 : 32'd1);
                check("s_cyc", {31'd0, s_cyc}, 32'd1);
                check("s_stb", {31'd0, s_stb}, 32'd1);
                check("s_we", {31'd0, s_we}, {31'd0, m_we[g]});
                check("s_sel", {28'd0, s_sel}, {28'd0, m_sel[g]});
                check("s_adr", {4'd0, s_adr}, {4'd0, m_adr[g]});
                check("s_wdat", s_wdat, m_dat[g]);
                check("flag_gnt", {31'd0, flag}, {31'd0, exp_flag});
            end
            if (k == last) begin
                check("ack", {31'd0, ack_of(g)}, 32'd1);
                if (tmo) begin
                    check("tmo_dat", rd_of(g), 32'hBAD0_BAD0);
                    check("tmo_s_cyc", {31'd0, s_cyc}, 32'd0);
                    check("tmo_s_stb", {31'd0, s_stb}, 32'd0);
                end else begin
                    check("rd_dat", rd_of(g), rd);
                end
            end else begin
                check("wait_ack", {31'd0, ack_of(g)}, 32'd0);
                check("wait_dat", rd_of(g), 32'd0);
            end
            check("other_ack", {31'd0, ack_of(1 - g)}, 32'd0);
        end
        if (tmo) exp_flag = 1'b1;
    endtask

    // DONE cycle (with an optional late slave ack) then the IDLE cycle.
    task automatic finish(input int g, input bit late_ack);
        @(negedge clk);
        m_cyc[g] = 1'b0;
        m_stb[g] = 1'b0;
        clr      = 1'b0;
        s_ack    = late_ack;
        s_rdat   = $urandom;
        #1;
        check("done_grant", {30'd0, grant}, 32'd0);
        check("done_s_cyc", {31'd0, s_cyc}, 32'd0);
        check("done_s_stb", {31'd0, s_stb}, 32'd0);
        check("done_ack0", {31'd0, m0_ack}, 32'd0);
        check("done_ack1", {31'd0, m1_ack}, 32'd0);
        check("flag", {31'd0, flag}, {31'd0, exp_flag});
        @(negedge clk);
        s_ack = 1'b0;
        #1;
        check("idle_grant", {30'd0, grant}, 32'd0);
        check("idle_s_cyc", {31'd0, s_cyc}, 32'd0);
    endtask

    // Called in an IDLE cycle; raises the requests in reqset and serves them.
    task automatic round(input int reqset, input int w0, input bit t0, input int w1, input bit t1);
        int win, lose;
        if ($urandom_range(0, 3) == 0) begin
            clr      = 1'b1;
            exp_flag = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (reqset[i]) begin
                m_cyc[i] = 1'b1;
                m_stb[i] = 1'b1;
            end
        end
        #1;
        check("req_no_leak", {31'd0, s_cyc}, 32'd0);
        check("req_grant", {30'd0, grant}, 32'd0);
        if (reqset == 3) win = 1 - prev_winner;
        else             win = (reqset == 2) ? 1 : 0;
        serve(win, (win == 1) ? w1 : w0, (win == 1) ? t1 : t0);
        finish(win, (win == 1) ? t1 : t0);
        if (reqset == 3) begin
            lose = 1 - win;
            serve(lose, (lose == 1) ? w1 : w0, (lose == 1) ? t1 : t0);
            finish(lose, (lose == 1) ? t1 : t0);
        end
        check("stat_m0", {16'd0, st0}, {16'd0, exp_st(0)});
        check("stat_m1", {16'd0, st1}, {16'd0, exp_st(1)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rs;
        rst    = 1'b1;
        clr    = 1'b0;
        s_ack  = 1'b0;
        s_rdat = '0;
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
            m_sel[i] = '0;   m_adr[i] = '0;   m_dat[i] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
        check("rst_ack0", {31'd0, m0_ack}, 32'd0);
        check("rst_ack1", {31'd0, m1_ack}, 32'd0);
        check("rst_flag", {31'd0, flag}, 32'd0);
        check("rst_st0", {16'd0, st0}, 32'd0);
        check("rst_st1", {16'd0, st1}, 32'd0);

        // Ties right after reset: M0, M1, M0, M1
        setup(0); setup(1);
        round(3, 0, 0, 0, 0);
        setup(0); setup(1);
        round(3, 0, 0, 0, 0);

        // M0 single write, two wait states
        m_we[0] = 1'b1; m_adr[0] = 28'h10; m_dat[0] = 32'hCAFE_F00D; m_sel[0] = 4'hF;
        round(1, 2, 0, 0, 0);

        // M1 read that never gets acked
        setup(1); m_we[1] = 1'b0;
        round(2, 0, 0, 0, 1);
        check("flag_set", {31'd0, flag}, 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_flag = 1'b0;
        #1;
        check("flag_clr", {31'd0, flag}, 32'd0);

        // M0 aborts after one granted cycle while M1 is waiting
        setup(0); setup(1);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        @(negedge clk);
        #1;
        check("abort_grant", {30'd0, grant}, 32'd1);
        prev_winner = 0;
        exp_stat[0]++;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        @(negedge clk);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        #1;
        check("abort_s_cyc", {31'd0, s_cyc}, 32'd0);
        check("abort_ack0", {31'd0, m0_ack}, 32'd0);
        finish(0, 0);
        serve(1, 0, 0);
        finish(1, 0);

        // Timeout to set the flag, then reset mid-GNT0 with a slave ack
        setup(0);
        round(1, 0, 1, 0, 0);
        setup(0);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        @(negedge clk);
        #1;
        check("pre_rst_grant", {30'd0, grant}, 32'd1);
        rst    = 1'b1;
        s_ack  = 1'b1;
        s_rdat = $urandom;
        #1;
        check("rst_drop_ack0", {31'd0, m0_ack}, 32'd0);
        check("rst_drop_dat0", m0_rd, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        s_ack = 1'b0;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        model_reset();
        #1;
        check("post_rst_grant", {30'd0, grant}, 32'd0);
        check("post_rst_s_cyc", {31'd0, s_cyc}, 32'd0);
        check("post_rst_flag", {31'd0, flag}, 32'd0);
        check("post_rst_st0", {16'd0, st0}, 32'd0);
        check("post_rst_st1", {16'd0, st1}, 32'd0);
        setup(0); setup(1);
        round(3, 1, 0, 0, 0);

        // Randomized rounds
        repeat (30) begin
            rs = $urandom_range(1, 3);
            setup(0); setup(1);
            round(rs, $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
                      $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                #1;
                check("gap_grant", {30'd0, grant}, 32'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_bus_arbiter.md
Name: aes_bus_arbiter

Overview:
- Two-master Wishbone arbiter that shares the single AES accelerator slave port.
- M0 is the Caravel management Wishbone (wbs_*). M1 is a debug master driven from logic-analyzer bits.
- Sits in accelerator_top between the bus sources and the AES core's io_bus_* interface.
- Provides round-robin grant, per-transaction grant hold, slave timeout recovery, and a sticky timeout flag readable on the LA.

Parameters:
ADDR_W, 28, slave address width forwarded to io_bus_addr
TIMEOUT_CYCLES, 255, max cycles a granted transaction may wait for slave ack (1..65535)

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  synchronous active-high reset
m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls
m0_sel_i  in  4  master 0 byte select
m0_adr_i  in  ADDR_W  master 0 address
m0_dat_i  in  32  master 0 write data
m0_ack_o  out  1  master 0 ack
m0_dat_o  out  32  master 0 read data
m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i, m1_ack_o, m1_dat_o  same as m0, for master 1
s_cyc_o, s_stb_o, s_we_o  out  1 each  to AES io_bus_cyc/stb/we
s_sel_o  out  4  to io_bus_sel
s_adr_o  out  ADDR_W  to io_bus_addr
s_dat_o  out  32  to io_bus_data_wr
s_ack_i  in  1  from io_bus_ack
s_dat_i  in  32  from io_bus_data_rd
timeout_flag_o  out  1  sticky; set on any timeout
timeout_clr_i  in  1  clears timeout_flag_o
grant_o  out  2  one-hot current grant {m1,m0}; 00 in IDLE
stat_m0_o, stat_m1_o  out  16 each  grant counters (see Optional Feature)

Behaviour:
- Request: reqN = mN_cyc_i & mN_stb_i.
- FSM states: IDLE, GNT0, GNT1, DONE. Reset -> IDLE, last_grant = 1 (M0 wins the first tie).
- IDLE:
  - Only req0 -> GNT0. Only req1 -> GNT1.
  - Both -> master != last_grant; last_grant updated on entry.
  - Decision registered: request sampled in cycle N, slave sees stb in cycle N+1.
- GNTx:
  - s_* outputs are combinational copies of master x inputs.
  - Non-granted master sees ack=0, dat=0.
  - mx_ack_o = s_ack_i; mx_dat_o = s_dat_i, gated to 0 when ack=0.
  - On s_ack_i -> DONE.
  - If mx_cyc_i drops before ack (abort) -> DONE; the slave sees cyc=0 the same cycle.
- Timeout:
  - A counter clears on GNT entry and increments each GNT cycle.
  - When it reaches TIMEOUT_CYCLES without ack, the arbiter drives a one-cycle mx_ack_o=1 with mx_dat_o=32'hBAD0_BAD0, forces s_cyc_o/s_stb_o=0 that cycle, sets timeout_flag_o, then -> DONE.
  - A late s_ack_i after timeout is ignored.
- DONE:
  - One idle cycle: all s_* = 0, all acks 0. This guarantees the master drops stb before re-arbitration.
  - Then -> IDLE.
- Minimum spacing between back-to-back transactions is 3 cycles (IDLE, GNT with 0-wait ack, DONE).
- timeout_flag_o:
  - Sets on timeout and clears on timeout_clr_i.
  - Set and clear in the same cycle: set wins.
- Reset values, and the state in the cycle after reset asserts (including mid-transaction):
  - All outputs 0; grant_o=00; counters 0.
  - Any in-flight transaction is dropped with no ack.
- In IDLE, s_* outputs are 0 (no master leakage to the slave).

Optional Feature:
Macro ARB_STATS_EN.
- Defined:
  - stat_m0_o/stat_m1_o count grants (GNT entries) per master.
  - 16-bit, saturating at 16'hFFFF.
  - Reset to 0 on wb_rst_i only.
- Undefined:
  - Both ports tied to 16'h0000.
  - No counter registers synthesized.

Test Plan:
1. M0 single write (adr 0x10, dat 0xCAFEF00D), slave acks after 2 wait states -> s_stb_o high from cycle 1 after req; m0_ack_o exactly one cycle; m1_ack_o stays 0; grant_o 01 then 00.
2. M0 and M1 request in the same cycle after reset, repeated 4 back-to-back transactions -> grant order M0, M1, M0, M1; DONE idle cycle between each; stat counters 2/2 with ARB_STATS_EN.
3. Granted M1 read, slave never acks, TIMEOUT_CYCLES=8 -> m1_ack_o pulses at grant+8 with dat 0xBAD0BAD0; timeout_flag_o=1; late slave ack ignored; timeout_clr_i clears the flag.
4. M0 drops cyc after 1 granted cycle (abort) -> s_cyc_o falls the same cycle; no m0_ack_o; FSM DONE then IDLE; a pending M1 request is granted next.
5. wb_rst_i asserted mid-GNT0 with slave ack arriving the same cycle -> no m0_ack_o; all outputs 0 next cycle; the first post-reset tie grants M0.
6. Build without ARB_STATS_EN, run scenario 2 -> stat_m0_o/stat_m1_o remain 0; arbitration results identical.
